// File: rtl/kv_sched_pkg.sv
// Package shared by the kv_update_scheduler slice.
//  - KV_MAX_REQ / KV_REQ_IW : upper bound on requester count and index width
//  - rr_pick                : rotating-priority pick. Returns a one-hot vector
//                             selecting the first valid requester at or after ptr.
// The queue entry type is declared inside kv_update_scheduler because it
// depends on that module's KEY_WIDTH/VAL_WIDTH parameters.
package kv_sched_pkg;

    localparam int KV_MAX_REQ = 32;
    localparam int KV_REQ_IW  = 5;

    // Scans n requesters starting at ptr and wrapping at n.
    // Bits at or above n are never set.
    function automatic logic [KV_MAX_REQ-1:0] rr_pick(
        input logic [KV_MAX_REQ-1:0] valid,
        input int unsigned           ptr,
        input int unsigned           n
    );
        logic [KV_MAX_REQ-1:0] g;
        int unsigned           idx;
        g = '0;
        for (int unsigned i = 0; i < KV_MAX_REQ; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (valid[idx[KV_REQ_IW-1:0]] && (g == '0)) begin
                    g[idx[KV_REQ_IW-1:0]] = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/kv_update_scheduler_rr_arbiter.sv
// Round-robin arbiter holding the rotating-priority pointer.
// Ports:
//  clk, reset_n   clock, asynchronous active-low reset
//  req            per-requester request (already qualified as admissible)
//  enable         when low, no grant is issued
//  advance        a grant was taken this cycle; pointer moves past it
//  grant          one-hot or zero
// The pointer resets to 0 and only moves on advance, so a cycle with no
// accepted request (full queue, flush) leaves the priority order untouched.
module rr_arbiter
    import kv_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]           ptr_q, ptr_d;
    logic [KV_MAX_REQ-1:0]   req_ext;
    logic [KV_MAX_REQ-1:0]   pick;
    logic [KV_REQ_IW-1:0]    gidx;
    logic                    any;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        pick                = rr_pick(req_ext, 32'(ptr_q), NREQ);
        gidx                = '0;
        for (int i = 0; i < KV_MAX_REQ; i++) begin
            if (pick[i]) gidx = KV_REQ_IW'(i);
        end
        any = |pick;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = enable & any & (gidx == KV_REQ_IW'(i));
        end
        ptr_d = ptr_q;
        if (advance) begin
            if (int'(gidx) + 1 >= NREQ) ptr_d = '0;
            else                        ptr_d = PW'(gidx + KV_REQ_IW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/kv_update_scheduler.sv
// Shares the single update port of a combinational key-value store between
// NREQ requesters through a DEPTH-entry in-order write queue.
// Ports:
//  clk, reset_n                clock, asynchronous active-low reset
//  req_valid/key/value         per-requester update request (flattened vectors)
//  req_ready                   one-hot or zero grant
//  pause                       hold the drain; requests are still accepted
//  flush                       drop every queued update on the next edge
//  update_valid/key/value      to the store; head entry, popped on the same edge
//  pending                     number of queued entries
// Handshake: a request transfers on an edge where req_valid[r] & req_ready[r].
// req_ready is a combinational function of req_valid/req_key and state, so a
// requester must never derive req_valid from req_ready. The store side has no
// backpressure: update_valid high means the head is consumed at that edge.
module kv_update_scheduler
    import kv_sched_pkg::*;
#(
    parameter int KEY_WIDTH = 32,
    parameter int VAL_WIDTH = 32,
    parameter int NREQ      = 2,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*KEY_WIDTH-1:0] req_key,
    input  logic [NREQ*VAL_WIDTH-1:0] req_value,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      pause,
    input  logic                      flush,
    output logic                      update_valid,
    output logic [KEY_WIDTH-1:0]      update_key,
    output logic [VAL_WIDTH-1:0]      update_value,
    output logic [$clog2(DEPTH):0]    pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] value;
    } kv_entry_t;

    kv_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              pop;
    logic [DEPTH-1:0]  occ;
    logic [NREQ-1:0]   hit;
    logic [AW-1:0]     hit_idx [NREQ];
    logic [NREQ-1:0]   admissible;
    logic [NREQ-1:0]   grant;
    logic              accept;
    logic              sel_hit;
    logic [AW-1:0]     sel_hidx;
    kv_entry_t         sel_entry;
    logic [AW-1:0]     wr_idx;
    logic              append;

    // Drain straight from the registered head.
    assign pop          = (count_q != '0) & ~pause & ~flush;
    assign update_valid = pop;
    assign update_key   = mem_q[head_q].key;
    assign update_value = mem_q[head_q].value;
    assign pending      = count_q;

    // Slot i is live when its distance from head is below the count.
    always_comb begin
        logic [AW-1:0] off;
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = AW'(i) - head_q;
            occ[i] = ({1'b0, off} < count_q);
        end
    end

    // Coalesce lookup. The head is excluded while it is leaving, so a request
    // matching the outgoing head appends a fresh entry instead of being lost.
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            hit[r]     = 1'b0;
            hit_idx[r] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && !(pop && (AW'(i) == head_q)) &&
                    (mem_q[i].key == req_key[r*KEY_WIDTH +: KEY_WIDTH])) begin
                    hit[r]     = 1'b1;
                    hit_idx[r] = AW'(i);
                end
            end
            // A slot freed by this cycle's pop is not counted as free.
            admissible[r] = hit[r] | (count_q < CW'(DEPTH));
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid & admissible),
        .enable  (~flush & reset_n),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_hit   = 1'b0;
        sel_hidx  = '0;
        sel_entry = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                sel_hit         = hit[r];
                sel_hidx        = hit_idx[r];
                sel_entry.key   = req_key[r*KEY_WIDTH +: KEY_WIDTH];
                sel_entry.value = req_value[r*VAL_WIDTH +: VAL_WIDTH];
            end
        end
        append = accept & ~sel_hit;
        // A coalesce rewrites the matched slot; the key is unchanged by construction.
        wr_idx = sel_hit ? sel_hidx : tail_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)    head_d = head_q + AW'(1);
            if (append) tail_d = tail_q + AW'(1);
            count_d = count_q + CW'(append) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (accept) mem_q[wr_idx] <= sel_entry;
        end
    end

    // Coalescing keeps every live key unique.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = i + 1; j < DEPTH; j++) begin
                    assert (!(occ[i] && occ[j] && (mem_q[i].key == mem_q[j].key)))
                        else $error("duplicate key in queue slots %0d and %0d", i, j);
                end
            end
        end
    end

endmodule

// File: tb/tb_kv_update_scheduler.sv
module tb_kv_update_scheduler;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int NR = 2;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR*KW-1:0] req_key;
  logic [NR*VW-1:0] req_value;
  logic [NR-1:0]    req_ready;
  logic             pause;
  logic             flush;
  logic             update_valid;
  logic [KW-1:0]    update_key;
  logic [VW-1:0]    update_value;
  logic [2:0]       pending;

  int checks = 0;
  int errors = 0;
  logic [KW+VW-1:0] exp_q[$];
  logic [KW+VW-1:0] mon_exp;

  kv_update_scheduler #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .NREQ(NR), .DEPTH(DP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_key      (req_key),
    .req_value    (req_value),
    .req_ready    (req_ready),
    .pause        (pause),
    .flush        (flush),
    .update_valid (update_valid),
    .update_key   (update_key),
    .update_value (update_value),
    .pending      (pending)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [KW-1:0] k, input logic [VW-1:0] v);
    req_valid[r]          = 1'b1;
    req_key[r*KW +: KW]   = k;
    req_value[r*VW +: VW] = v;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  // Presents one request for one cycle and expects it to be granted.
  task automatic send(input int r, input logic [KW-1:0] k, input logic [VW-1:0] v, input string tag);
    logic [NR-1:0] e;
    e = NR'(1) << r;
    set_req(r, k, v);
    @(negedge clk);
    check(tag, 64'(req_ready), 64'(e));
    next_cycle();
    clr_req();
  endtask

  task automatic push_exp(input logic [KW-1:0] k, input logic [VW-1:0] v);
    exp_q.push_back({k, v});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1 && update_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL update_unexpected: got key %0h value %0h, expected none", update_key, update_value);
      end else begin
        mon_exp = exp_q.pop_front();
        check("update", {update_key, update_value}, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_key   = '0;
    req_value = '0;
    pause     = 1'b0;
    flush     = 1'b0;

    // Reset state, with requests asserted to show ready stays low.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_update_valid", 64'(update_valid), 64'd0);
    check("rst_update_key", 64'(update_key), 64'd0);
    check("rst_update_value", 64'(update_value), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    clr_req();
    reset_n = 1'b1;
    next_cycle();

    // Round-robin: both requesters always valid; grants alternate 0,1,0,1.
    begin
      int i0 = 0;
      int i1 = 0;
      for (int c = 0; c < 6; c++) begin
        set_req(0, 32'h100 + i0, 32'h1000 + i0);
        set_req(1, 32'h200 + i1, 32'h2000 + i1);
        if (c % 2 == 0) push_exp(32'h100 + i0, 32'h1000 + i0);
        else            push_exp(32'h200 + i1, 32'h2000 + i1);
        @(negedge clk);
        check("rr_grant", 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
        check("rr_pending", 64'(pending), (c == 0) ? 64'd0 : 64'd1);
        next_cycle();
        if (c % 2 == 0) i0++;
        else            i1++;
      end
      clr_req();
      repeat (3) next_cycle();
      check("rr_drained", 64'(exp_q.size()), 64'd0);
    end

    // Coalesce while paused.
    pause = 1'b1;
    send(0, 32'h40, 32'd1, "coal_rdy0");
    send(0, 32'h44, 32'd2, "coal_rdy1");
    send(0, 32'h40, 32'd9, "coal_rdy2");
    @(negedge clk);
    check("coal_pending", 64'(pending), 64'd2);
    push_exp(32'h40, 32'd9);
    push_exp(32'h44, 32'd2);
    next_cycle();
    pause = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    check("coal_pending_end", 64'(pending), 64'd0);
    check("coal_drained", 64'(exp_q.size()), 64'd0);
    next_cycle();

    // Full queue: new key refused, coalescing key accepted.
    pause = 1'b1;
    send(0, 32'h40, 32'd1, "full_rdy0");
    send(0, 32'h44, 32'd2, "full_rdy1");
    send(0, 32'h48, 32'd3, "full_rdy2");
    send(0, 32'h4C, 32'd4, "full_rdy3");
    @(negedge clk);
    check("full_pending", 64'(pending), 64'd4);
    next_cycle();
    set_req(0, 32'h80, 32'd8);
    @(negedge clk);
    check("full_refuse", 64'(req_ready), 64'd0);
    next_cycle();
    clr_req();
    send(1, 32'h44, 32'd7, "full_coalesce");
    @(negedge clk);
    check("full_pending2", 64'(pending), 64'd4);
    push_exp(32'h40, 32'd1);
    push_exp(32'h44, 32'd7);
    push_exp(32'h48, 32'd3);
    push_exp(32'h4C, 32'd4);
    next_cycle();
    pause = 1'b0;
    repeat (6) next_cycle();
    check("full_drained", 64'(exp_q.size()), 64'd0);
    check("full_pending_end", 64'(pending), 64'd0);

    // Head race: request matching the departing head appends.
    pause = 1'b1;
    send(0, 32'h10, 32'd1, "race_rdy0");
    push_exp(32'h10, 32'd1);
    push_exp(32'h10, 32'd5);
    pause = 1'b0;
    set_req(0, 32'h10, 32'd5);
    @(negedge clk);
    check("race_rdy1", 64'(req_ready), 64'd1);
    check("race_head_valid", 64'(update_valid), 64'd1);
    next_cycle();
    clr_req();
    @(negedge clk);
    check("race_pending", 64'(pending), 64'd1);
    next_cycle();
    @(negedge clk);
    check("race_pending_end", 64'(pending), 64'd0);
    check("race_drained", 64'(exp_q.size()), 64'd0);
    next_cycle();

    // Flush: pointer is 1 here and must survive the flush.
    pause = 1'b1;
    send(0, 32'h20, 32'h200, "flush_rdy0");
    send(0, 32'h24, 32'h240, "flush_rdy1");
    send(0, 32'h28, 32'h280, "flush_rdy2");
    flush = 1'b1;
    set_req(0, 32'h30, 32'h300);
    set_req(1, 32'h34, 32'h340);
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'd0);
    check("flush_update_valid", 64'(update_valid), 64'd0);
    check("flush_pending_before", 64'(pending), 64'd3);
    next_cycle();
    flush = 1'b0;
    pause = 1'b0;
    push_exp(32'h34, 32'h340);
    @(negedge clk);
    check("flush_pending_after", 64'(pending), 64'd0);
    check("flush_rr_held", 64'(req_ready), 64'd2);
    next_cycle();
    req_valid[1] = 1'b0;
    push_exp(32'h30, 32'h300);
    @(negedge clk);
    check("flush_rr_next", 64'(req_ready), 64'd1);
    next_cycle();
    clr_req();
    repeat (3) next_cycle();
    check("flush_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with three queued entries and the drain enabled.
    pause = 1'b1;
    send(0, 32'h50, 32'd1, "arst_rdy0");
    send(1, 32'h54, 32'd2, "arst_rdy1");
    send(0, 32'h58, 32'd3, "arst_rdy2");
    pause = 1'b0;
    #1;
    check("arst_pre_valid", 64'(update_valid), 64'd1);
    check("arst_pre_pending", 64'(pending), 64'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_update_valid", 64'(update_valid), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) next_cycle();
    check("arst_pending_end", 64'(pending), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
